// File: rtl/dsp_mac_sequencer.sv
// Dot-product sequencer driving a 3-stage pipelined signed multiplier slice.
// Products are chained into the running sum through the slice's PCIN/SEL path,
// bubbles feed zeros with CE held high, and the sum is returned on a
// valid/ready result port after the pipeline drains.
module dsp_mac_sequencer #(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned DSP_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_a,
    input  logic [31:0]      s_b,
    output logic             dsp_ce,
    output logic             dsp_sclr,
    output logic             dsp_sel,
    output logic [31:0]      dsp_a,
    output logic [31:0]      dsp_b,
    output logic [47:0]      dsp_pcin,
    input  logic [31:0]      dsp_p,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PCIN_W = 48;
    localparam int unsigned CNT_W  = $clog2(DSP_LAT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   remaining, remaining_nxt;
    logic [CNT_W-1:0]   drain_cnt, drain_nxt;
    logic [DATA_W-1:0]  result_nxt;
    logic               cmd_ready_nxt, s_ready_nxt, m_valid_nxt;
    logic               ce_nxt, sclr_nxt;
    logic               cmd_fire, s_fire;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign s_fire   = s_valid & s_ready;

    // Chain input is the sign-extended running sum fed back from the slice
    assign dsp_pcin = {{(PCIN_W - DATA_W){dsp_p[DATA_W-1]}}, dsp_p};

    // State register and registered handshake/DSP-control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            drain_cnt <= '0;
            m_data    <= '0;
            cmd_ready <= 1'b0;
            s_ready   <= 1'b0;
            m_valid   <= 1'b0;
            dsp_ce    <= 1'b0;
            dsp_sclr  <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            drain_cnt <= drain_nxt;
            m_data    <= result_nxt;
            cmd_ready <= cmd_ready_nxt;
            s_ready   <= s_ready_nxt;
            m_valid   <= m_valid_nxt;
            dsp_ce    <= ce_nxt;
            dsp_sclr  <= sclr_nxt;
        end
    end

    // Next-state, counters, operand steering and next values of registered outputs
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        drain_nxt     = drain_cnt;
        result_nxt    = m_data;
        dsp_sel       = 1'b0;
        dsp_a         = '0;
        dsp_b         = '0;

        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    remaining_nxt = cmd_len;
                    state_nxt     = CLEAR;
                end
            end
            CLEAR: begin
                result_nxt = '0;
                state_nxt  = (remaining == '0) ? DONE : RUN;
            end
            RUN: begin
                dsp_sel = 1'b1;
                if (s_fire) begin
                    dsp_a         = s_a;
                    dsp_b         = s_b;
                    remaining_nxt = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        drain_nxt = CNT_W'(DSP_LAT);
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                dsp_sel   = 1'b1;
                drain_nxt = drain_cnt - CNT_W'(1);
                if (drain_cnt == CNT_W'(1)) begin
                    result_nxt = dsp_p;
                    state_nxt  = DONE;
                end
            end
            DONE: begin
                if (m_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // CE stays high from CLEAR through the drain capture so the pipe is never flushed
        ce_nxt        = (state_nxt == CLEAR) || (state_nxt == RUN) || (state_nxt == DRAIN);
        sclr_nxt      = (state_nxt == CLEAR);
        cmd_ready_nxt = (state_nxt == IDLE);
        s_ready_nxt   = (state_nxt == RUN) && (remaining_nxt != '0);
        m_valid_nxt   = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural 3-stage multiplier slice.
module tb_dsp_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_len;
    logic        s_valid, s_ready;
    logic [31:0] s_a, s_b;
    logic        dsp_ce, dsp_sclr, dsp_sel;
    logic [31:0] dsp_a, dsp_b, dsp_p;
    logic [47:0] dsp_pcin;
    logic        m_valid, m_ready;
    logic [31:0] m_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0, sclr_cnt = 0, srdy_cnt = 0, mv_cnt = 0;
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic [15:0]      len;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        logic [3:0][7:0]  gap;   // bubble cycles in RUN before each pair
        logic [7:0]       hold;  // cycles M_READY stays low after M_VALID
        logic [31:0]      exp;
        logic [7:0]       lat;   // CMD fire to M_VALID, 0 = not checked
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    dsp_mac_sequencer #(.LEN_W(16), .DSP_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .dsp_ce(dsp_ce), .dsp_sclr(dsp_sclr), .dsp_sel(dsp_sel),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_pcin(dsp_pcin), .dsp_p(dsp_p),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    // Multiplier slice model: input reg, mult reg, P reg; CE low or SCLR clears it
    logic [31:0] ar, br, mr, pr;
    always @(posedge clk) begin
        if (!dsp_ce || dsp_sclr) begin
            ar <= '0; br <= '0; mr <= '0; pr <= '0;
        end else begin
            ar <= dsp_a;
            br <= dsp_b;
            mr <= ar * br;
            pr <= dsp_sel ? (dsp_pcin[31:0] + mr) : mr;
        end
    end
    assign dsp_p = pr;

    // Cycle counter and event counters
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dsp_sclr) sclr_cnt <= sclr_cnt + 1;
        if (s_ready)  srdy_cnt <= srdy_cnt + 1;
        if (m_valid)  mv_cnt   <= mv_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] len, input logic [127:0] a,
                                input logic [127:0] b, input logic [31:0] gap,
                                input logic [7:0] hold, input logic [31:0] exp,
                                input logic [7:0] lat);
        vec_t v;
        v.len = len; v.a = a; v.b = b; v.gap = gap;
        v.hold = hold; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input int gap);
        int n = 0;
        s_valid = 1'b0;
        while (!s_ready && n < 50) begin step(); n++; end
        chk("s_ready_wait", 32'(s_ready), 32'd1);
        for (int g = 0; g < gap; g++) begin
            s_a = 32'hDEADBEEF;
            s_b = 32'h12345678;
            #1;
            chk("bubble_dsp_a", dsp_a, 32'd0);
            chk("bubble_dsp_b", dsp_b, 32'd0);
            chk("bubble_ce", 32'(dsp_ce), 32'd1);
            step();
        end
        s_valid = 1'b1;
        s_a = a;
        s_b = b;
        #1;
        chk("fire_dsp_a", dsp_a, a);
        chk("fire_dsp_b", dsp_b, b);
        step();
        s_valid = 1'b0;
        s_a = '0;
        s_b = '0;
    endtask

    task automatic accept_cmd(input logic [15:0] len, output int t_fire);
        int n = 0;
        cmd_len = len;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin step(); n++; end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        t_fire = cyc;
        step();
        cmd_valid = 1'b0;
        cmd_len = '0;
    endtask

    task automatic run_vec(input vec_t v);
        int n = 0;
        int t_fire;
        int s_sclr = sclr_cnt;
        int s_srdy = srdy_cnt;
        logic [31:0] e;
        m_ready = (v.hold == 8'd0);
        exp_q.push_back(v.exp);
        accept_cmd(v.len, t_fire);
        for (int i = 0; i < int'(v.len) && i < 4; i++)
            send_pair(v.a[i], v.b[i], int'(v.gap[i]));
        while (!m_valid && n < 200) begin step(); n++; end
        chk("m_valid_wait", 32'(m_valid), 32'd1);
        if (v.lat != 8'd0)
            chk("latency", 32'(cyc - t_fire), 32'(v.lat));
        for (int k = 0; k < int'(v.hold); k++) begin
            cmd_valid = 1'b1;
            cmd_len = 16'd7;
            chk("hold_m_valid", 32'(m_valid), 32'd1);
            chk("hold_m_data", m_data, v.exp);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            step();
        end
        cmd_valid = 1'b0;
        cmd_len = '0;
        m_ready = 1'b1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got result with empty queue, expected queued entry");
        end else begin
            e = exp_q.pop_front();
            chk("m_data", m_data, e);
        end
        step();
        chk("m_valid_one_cycle", 32'(m_valid), 32'd0);
        chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
        chk("sclr_pulses", 32'(sclr_cnt - s_sclr), 32'd1);
        if (v.len == 16'd0)
            chk("len0_s_ready", 32'(srdy_cnt - s_srdy), 32'd0);
    endtask

    initial begin
        int t_fire;
        int mv0;
        vecs[0] = mk(16'd4, {32'd7, 32'd5, 32'd3, 32'd1}, {32'd8, 32'd6, 32'd4, 32'd2},
                     32'd0, 8'd0, 32'd100, 8'd9);
        vecs[1] = mk(16'd2, {64'd0, 32'd2, 32'hFFFFFFFD}, {64'd0, 32'hFFFFFFF9, 32'd5},
                     {8'd0, 8'd0, 8'd3, 8'd0}, 8'd0, 32'hFFFFFFE3, 8'd10);
        vecs[2] = mk(16'd0, 128'd0, 128'd0, 32'd0, 8'd0, 32'd0, 8'd2);
        vecs[3] = mk(16'd2, {64'd0, 32'h7FFFFFFF, 32'h00010000}, {64'd0, 32'd1, 32'h00010000},
                     32'd0, 8'd0, 32'h7FFFFFFF, 8'd7);
        vecs[4] = mk(16'd1, {96'd0, 32'hFFFFFFFF}, {96'd0, 32'hFFFFFFFF},
                     32'd0, 8'd0, 32'd1, 8'd6);
        vecs[5] = mk(16'd3, {32'd0, 32'd6, 32'd4, 32'd2}, {32'd0, 32'd7, 32'd5, 32'd3},
                     32'd0, 8'd5, 32'd68, 8'd8);
        vecs[6] = mk(16'd3, {32'd0, 32'h80000000, 32'd100, 32'hFFFFFFFE},
                     {32'd0, 32'd2, 32'hFFFFFFFF, 32'd4},
                     {24'd0, 8'd2}, 8'd0, 32'hFFFFFF94, 8'd10);
        vecs[7] = mk(16'd1, {96'd0, 32'd6}, {96'd0, 32'd7}, 32'd0, 8'd0, 32'd42, 8'd6);

        rst_n = 1'b1;
        cmd_valid = 1'b0; cmd_len = '0;
        s_valid = 1'b0; s_a = '0; s_b = '0;
        m_ready = 1'b0;
        #2 rst_n = 1'b0;
        step(); step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_ce", 32'(dsp_ce), 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Operand stream is ignored while idle
        s_valid = 1'b1; s_a = 32'd5; s_b = 32'd5;
        #1;
        chk("idle_dsp_a", dsp_a, 32'd0);
        chk("idle_sel", 32'(dsp_sel), 32'd0);
        step();
        chk("idle_s_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b0; s_a = '0; s_b = '0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset in the middle of a 4-pair command discards the partial sum
        mv0 = mv_cnt;
        m_ready = 1'b1;
        accept_cmd(16'd4, t_fire);
        send_pair(32'd1, 32'd2, 0);
        send_pair(32'd3, 32'd4, 0);
        s_valid = 1'b1; s_a = 32'd9; s_b = 32'd9;
        rst_n = 1'b0;
        #1;
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_m_data", m_data, 32'd0);
        chk("midrst_ce", 32'(dsp_ce), 32'd0);
        chk("midrst_sclr", 32'(dsp_sclr), 32'd0);
        chk("midrst_sel", 32'(dsp_sel), 32'd0);
        chk("midrst_dsp_a", dsp_a, 32'd0);
        chk("midrst_dsp_b", dsp_b, 32'd0);
        s_valid = 1'b0; s_a = '0; s_b = '0;
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) step();
        chk("midrst_no_result", 32'(mv_cnt - mv0), 32'd0);

        run_vec(vecs[7]);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
